dcpu_mem: RTL and testbench
===========================

# dcpu_mem

Bus responder for the dcpu memory bus: decodes the CPU's `o_cs`/`o_addr`/`o_we`/`o_dat` request and answers with read data and a one-cycle `ack` after a programmable number of wait states. It holds a single-port word RAM mapped at a parameterised base address and sits between the CPU and the interconnect. Several instances with disjoint windows may share the same bus, with acks and read data OR-ed.

## Interface
- `ADDR_BITS`, default 12: RAM depth is 2^ADDR_BITS 16-bit words.
- `BASE`, default 16'h0000: first bus address of the window; must be aligned to 2^ADDR_BITS.
- `WAIT_STATES`, default 0: extra cycles before ack, range 0..15.
- `ROM_WORDS`, default 256: size of the write-protected region, used only with `DCPU_MEM_WP_EN`.
- `i_clk` in 1: clock. All state changes on the rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_cs` in 1: request valid (CPU `o_cs`).
- `i_we` in 1: 1 = write, 0 = read (CPU `o_we`).
- `i_addr` in 16: word address (CPU `o_addr`).
- `i_dat` in 16: write data (CPU `o_dat`).
- `o_dat` out 16: read data. Valid only while `o_ack`=1, otherwise 16'h0000.
- `o_ack` out 1: transaction complete. The CPU samples it, and `o_dat`, at the same rising edge.

## Operation
- Select: `sel = i_cs && (i_addr[15:ADDR_BITS] == BASE[15:ADDR_BITS])`. Index is `i_addr[ADDR_BITS-1:0]`.
- Requests that are not selected are ignored: no ack, no write, and the counter is held at 0.
- Storage: asynchronous-read RAM, not cleared by reset. `o_dat = o_ack ? mem[idx] : 0`.
- Write commit: `mem[idx] <= i_dat` at the rising edge where `o_ack && i_we`. Writes never commit without an ack.
- State: `cnt` is a 4-bit wait counter. `req_q` holds the latched `{i_addr, i_we}` of the request in progress.
- WAIT_STATES=0:
  - `o_ack = sel && !i_reset`, combinational, in the same cycle the request appears.
  - No counter or latch is used.
- WAIT_STATES=N>0:
  - First cycle of a selected request: latch `req_q`, set `cnt`=1.
  - Each following cycle with the request unchanged: `cnt` increments.
  - `o_ack = sel && cnt==N && {i_addr,i_we}==req_q && !i_reset`.
- At the ack edge `cnt` returns to 0, so the next cycle is a new transaction. Back-to-back reads of the same address are therefore acked separately.
- Abort: if `sel` drops, or `{i_addr,i_we}` differs from `req_q` before the ack, the transaction is abandoned.
  - Nothing is written.
  - A changed-but-still-selected request restarts: latch the new value and set `cnt`=1.
  - The CPU relies on this when it leaves execute for non-load/store stack ops without waiting.
- Write data is sampled only at the ack edge. `i_dat` changes during the wait cycles are permitted.

## Timing
- Reset values: `cnt`=0, `req_q`=0, `o_ack`=0, `o_dat`=16'h0000.
- Reset mid-transaction: the transaction is discarded and no write commits at that edge.
- Latency from the request's first cycle to ack: WAIT_STATES cycles, i.e. ack arrives in cycle WAIT_STATES+1 of a stable request.
- The ack is exactly one cycle wide per transaction.
- Throughput: one transaction per WAIT_STATES+1 cycles, with no dead cycle between transactions.
- Address wrap: there is none inside the window. An address one past the top of the window is outside it and gets no ack.

## Configuration
- `DCPU_MEM_WP_EN` defined:
  - Writes to `idx < ROM_WORDS` are acked with normal timing but the RAM is left unchanged.
  - Reads there are normal.
- `DCPU_MEM_WP_EN` undefined: the whole window is writable and `ROM_WORDS` is ignored.

## Test plan
- WAIT_STATES=0, BASE=0, preload mem[5]=16'hBEEF:
  - Read with cs=1, addr=5 → `o_ack`=1 in the same cycle with `o_dat`=16'hBEEF.
  - Then write 16'h1234 to addr 5 and read it back → 16'h1234.
- WAIT_STATES=2: read held on addr 7 → `o_ack` low for 2 cycles, high in cycle 3 for exactly 1 cycle. A consecutive read of addr 7 acks again 3 cycles later.
- WAIT_STATES=2 abort:
  - Write addr 3, then cs=0 after 1 cycle → no ack and mem[3] unchanged.
  - Change addr from 3 to 4 mid-wait → ack arrives 3 cycles after the change, at addr 4.
- BASE=16'h1000, ADDR_BITS=12: cs=1 at addr 16'h0FFF and at 16'h2000 → no ack. At 16'h1FFF → ack.
- Reset asserted in the cycle before a pending write ack (WAIT_STATES=1) → no ack, memory unchanged; after reset `cnt`=0 and `o_ack`=0.
- With `DCPU_MEM_WP_EN`, ROM_WORDS=256: write 16'hAAAA to addr 16'h00FF → acked, readback shows the old value. Write to addr 16'h0100 → readback 16'hAAAA.

Source files
------------

// File: rtl/dcpu_mem.sv
// dcpu_mem: word-RAM bus responder for the dcpu memory bus with programmable wait states.
// Define DCPU_MEM_WP_EN to write-protect the lowest ROM_WORDS words of the window.
module dcpu_mem #(
   parameter int unsigned ADDR_BITS   = 12,
   parameter logic [15:0] BASE        = 16'h0000,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned ROM_WORDS   = 256
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_cs,
   input  logic        i_we,
   input  logic [15:0] i_addr,
   input  logic [15:0] i_dat,
   output logic [15:0] o_dat,
   output logic        o_ack
);

   localparam int unsigned DEPTH = 1 << ADDR_BITS;

`ifdef DCPU_MEM_WP_EN
   localparam bit WP_ON = 1'b1;
`else
   localparam bit WP_ON = 1'b0;
`endif

   logic [15:0]          mem [DEPTH];
   logic                 sel;
   logic [ADDR_BITS-1:0] idx;
   logic                 ack;
   logic                 romHit;
   logic                 wrEn;

   assign sel    = i_cs && (i_addr[15:ADDR_BITS] == BASE[15:ADDR_BITS]);
   assign idx    = i_addr[ADDR_BITS-1:0];
   assign romHit = WP_ON && (32'(idx) < ROM_WORDS);
   // Protected writes still get a normal ack; only the RAM update is suppressed.
   assign wrEn   = ack && i_we && !romHit;

   generate
      if (WAIT_STATES == 0) begin : gNoWait
         assign ack = sel && !i_reset;
      end else begin : gWait
         logic [3:0]  cnt_q, cnt_d;
         logic [16:0] req_q, req_d;
         logic        reqSame;

         assign reqSame = ({i_addr, i_we} == req_q);
         assign ack     = sel && (cnt_q == 4'(WAIT_STATES)) && reqSame && !i_reset;

         // A request that is new, or differs from the latched one, restarts the wait.
         always_comb begin
            cnt_d = cnt_q;
            req_d = req_q;
            if (!sel || ack) begin
               cnt_d = 4'd0;
            end else if ((cnt_q != 4'd0) && reqSame) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               req_d = {i_addr, i_we};
               cnt_d = 4'd1;
            end
         end

         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               cnt_q <= 4'd0;
               req_q <= 17'd0;
            end else begin
               cnt_q <= cnt_d;
               req_q <= req_d;
            end
         end
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (wrEn) begin
         mem[idx] <= i_dat;
      end
   end

   assign o_ack = ack;
   assign o_dat = ack ? mem[idx] : 16'h0000;

endmodule

// File: tb/tb_dcpu_mem.sv
// tb_dcpu_mem: four dcpu_mem instances (different windows and wait states), each checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_dcpu_mem;

   localparam int NI = 4;

   function automatic int abOf(int k);
      return (k == 3) ? 4 : 12;
   endfunction
   function automatic int baseOf(int k);
      case (k)
         2:       return 'h1000;
         3:       return 'h0030;
         default: return 0;
      endcase
   endfunction
   function automatic int wsOf(int k);
      case (k)
         0:       return 0;
         1:       return 2;
         2:       return 1;
         default: return 3;
      endcase
   endfunction
   function automatic int romOf(int k);
      return (k == 3) ? 4 : 256;
   endfunction

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        csS   [NI];
   logic        weS   [NI];
   logic [15:0] addrS [NI];
   logic [15:0] datS  [NI];
   logic [15:0] datO  [NI];
   logic        ackO  [NI];
   int          vectors     = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   // Each instance gets its own model: a transaction is acked WS cycles after it started.
   for (genvar k = 0; k < NI; k++) begin : gInst
      localparam int AB = abOf(k);
      localparam int BS = baseOf(k);
      localparam int WS = wsOf(k);
      localparam int RW = romOf(k);

      dcpu_mem #(
         .ADDR_BITS(AB), .BASE(16'(BS)), .WAIT_STATES(WS), .ROM_WORDS(RW)
      ) dut (
         .i_clk(clk), .i_reset(rst), .i_cs(csS[k]), .i_we(weS[k]),
         .i_addr(addrS[k]), .i_dat(datS[k]), .o_dat(datO[k]), .o_ack(ackO[k])
      );

      logic [15:0] mMem [int];
      int          cyc      = 0;
      int          startCyc = 0;
      bit          prevLive = 1'b0;
      logic [16:0] prevReq  = '0;

      always @(negedge clk) begin : model
         int          a;
         int          idx;
         bit          sel;
         bit          expAck;
         bit          rom;
         logic [16:0] req;
         a   = int'(addrS[k]);
         sel = csS[k] && (a >= BS) && (a < BS + (1 << AB));
         idx = a - BS;
`ifdef DCPU_MEM_WP_EN
         rom = (idx < RW);
`else
         rom = 1'b0;
`endif
         req = {addrS[k], weS[k]};
         if (sel && !(prevLive && (req == prevReq))) startCyc = cyc;
         expAck = sel && !rst && ((cyc - startCyc) == WS);

         vectors++;
         if (ackO[k] !== expAck) begin
            miscompares++;
            $display("[TB] FAIL ack[%0d] cyc %0d addr %h: got %0b want %0b", k, cyc, addrS[k], ackO[k], expAck);
         end
         if (!expAck) begin
            vectors++;
            if (datO[k] !== 16'h0000) begin
               miscompares++;
               $display("[TB] FAIL idleDat[%0d] cyc %0d: got %h want 0000", k, cyc, datO[k]);
            end
         end else if (mMem.exists(idx)) begin
            vectors++;
            if (datO[k] !== mMem[idx]) begin
               miscompares++;
               $display("[TB] FAIL rdDat[%0d] cyc %0d idx %0d: got %h want %h", k, cyc, idx, datO[k], mMem[idx]);
            end
         end

         if (expAck && weS[k] && !rom) mMem[idx] = datS[k];
         prevLive = sel && !rst && !expAck;
         prevReq  = req;
         cyc++;
      end
   end

   // Drive one instance for one cycle and stop at the sampling edge.
   task automatic applyStimulus(input int k, input logic cs, input logic we,
                                input logic [15:0] addr, input logic [15:0] dat);
      @(posedge clk);
      #1;
      csS[k]   = cs;
      weS[k]   = we;
      addrS[k] = addr;
      datS[k]  = dat;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   function automatic logic [15:0] randAddr(int k);
      int b;
      int sz;
      int r;
      b  = baseOf(k);
      sz = 1 << abOf(k);
      r  = $urandom_range(0, 9);
      if (r <= 5)      return 16'(b + $urandom_range(0, 7));
      else if (r == 6) return 16'(b + sz - 1);
      else if (r == 7) return 16'(b + sz - 2);
      else if (r == 8) return 16'(b + sz);
      else             return 16'(b - 1);
   endfunction

   initial begin
      for (int k = 0; k < NI; k++) begin
         csS[k] = 1'b0; weS[k] = 1'b0; addrS[k] = '0; datS[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Zero wait states: same-cycle ack, write then read back.
      applyStimulus(0, 1, 1, 16'd5, 16'hBEEF);
      checkOutput("ws0 write ack", 16'(ackO[0]), 16'h1);
      applyStimulus(0, 1, 0, 16'd5, 16'h0);
      checkOutput("ws0 read ack", 16'(ackO[0]), 16'h1);
      checkOutput("ws0 read BEEF", datO[0], 16'hBEEF);
      applyStimulus(0, 1, 1, 16'd5, 16'h1234);
      applyStimulus(0, 1, 0, 16'd5, 16'h0);
      checkOutput("ws0 read 1234", datO[0], 16'h1234);
`ifdef DCPU_MEM_WP_EN
      applyStimulus(0, 1, 1, 16'h00FF, 16'hAAAA);
      checkOutput("wp rom write ack", 16'(ackO[0]), 16'h1);
      applyStimulus(0, 1, 0, 16'h00FF, 16'h0);
      checkOutput("wp rom unchanged", 16'(datO[0] == 16'hAAAA), 16'h0);
      applyStimulus(0, 1, 1, 16'h0100, 16'hAAAA);
      applyStimulus(0, 1, 0, 16'h0100, 16'h0);
      checkOutput("wp ram written", datO[0], 16'hAAAA);
`endif
      applyStimulus(0, 0, 0, 16'h0, 16'h0);

      // Two wait states: ack every third cycle of a held request.
      repeat (3) applyStimulus(1, 1, 1, 16'd7, 16'h0707);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, 1, 0, 16'd7, 16'h0);
         checkOutput($sformatf("ws2 held read c%0d", i + 1), 16'(ackO[1]), 16'((i % 3) == 2));
      end
      checkOutput("ws2 read 0707", datO[1], 16'h0707);
      repeat (3) applyStimulus(1, 1, 1, 16'd3, 16'h3333);
      applyStimulus(1, 1, 1, 16'd3, 16'h5555);
      checkOutput("abort c1", 16'(ackO[1]), 16'h0);
      applyStimulus(1, 0, 1, 16'd3, 16'h5555);
      checkOutput("abort c2", 16'(ackO[1]), 16'h0);
      repeat (3) applyStimulus(1, 1, 0, 16'd3, 16'h0);
      checkOutput("abort keeps 3333", datO[1], 16'h3333);
      applyStimulus(1, 1, 0, 16'd3, 16'h0);
      checkOutput("restart before", 16'(ackO[1]), 16'h0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, 16'd4, 16'h0);
         checkOutput($sformatf("restart c%0d", i + 1), 16'(ackO[1]), 16'(i == 2));
      end
      applyStimulus(1, 0, 0, 16'h0, 16'h0);

      // Offset window: edges just outside get nothing, the top word is served.
      repeat (3) applyStimulus(2, 1, 0, 16'h0FFF, 16'h0);
      checkOutput("below window", 16'(ackO[2]), 16'h0);
      repeat (3) applyStimulus(2, 1, 0, 16'h2000, 16'h0);
      checkOutput("above window", 16'(ackO[2]), 16'h0);
      applyStimulus(2, 1, 0, 16'h1FFF, 16'h0);
      checkOutput("top c1", 16'(ackO[2]), 16'h0);
      applyStimulus(2, 1, 0, 16'h1FFF, 16'h0);
      checkOutput("top c2", 16'(ackO[2]), 16'h1);

      // Reset one cycle before the pending write ack discards the write.
      repeat (2) applyStimulus(2, 1, 1, 16'h1010, 16'h7777);
      applyStimulus(2, 1, 1, 16'h1010, 16'hDEAD);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("reset blocks ack", 16'(ackO[2]), 16'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      csS[2] = 1'b0;
      @(negedge clk);
      checkOutput("after reset idle", 16'(ackO[2]), 16'h0);
      applyStimulus(2, 1, 0, 16'h1010, 16'h0);
      checkOutput("post reset c1", 16'(ackO[2]), 16'h0);
      applyStimulus(2, 1, 0, 16'h1010, 16'h0);
      checkOutput("post reset c2", 16'(ackO[2]), 16'h1);
      checkOutput("reset kept 7777", datO[2], 16'h7777);
      applyStimulus(2, 0, 0, 16'h0, 16'h0);

      // Random traffic on all instances, requests usually held so waits complete.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         rst = ($urandom_range(0, 99) == 0);
         for (int k = 0; k < NI; k++) begin
            datS[k] = 16'($urandom);
            if (!(csS[k] && $urandom_range(0, 3) != 0)) begin
               csS[k]   = ($urandom_range(0, 6) != 0);
               weS[k]   = 1'($urandom_range(0, 1));
               addrS[k] = randAddr(k);
            end
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < NI; k++) csS[k] = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
